// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the branch/jump resolution unit.
//   - 6-bit control opcodes recognised by controle_desvio_seq
//   - FSM state encoding (RUN accepts instructions, FLUSH holds the flush window)
package ctrl_pkg;

  localparam logic [5:0] OP_JMP   = 6'd13;
  localparam logic [5:0] OP_JMPR  = 6'd14;
  localparam logic [5:0] OP_BEQ   = 6'd15;
  localparam logic [5:0] OP_BNEQ  = 6'd16;
  localparam logic [5:0] OP_BLZ   = 6'd17;
  localparam logic [5:0] OP_JAL   = 6'd26;
  localparam logic [5:0] OP_BEQI  = 6'd27;
  localparam logic [5:0] OP_BNEQI = 6'd28;
  localparam logic [5:0] OP_BLT   = 6'd40;
  localparam logic [5:0] OP_BGRT  = 6'd41;
  localparam logic [5:0] OP_BLTI  = 6'd42;
  localparam logic [5:0] OP_BGRTI = 6'd43;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/controle_desvio_seq_ras_stack.sv
// ras_stack: return-address stack (LIFO) for jal/jmpr.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset (pointer only)
//   push, pop     : write din on top / discard top; never both in one cycle
//   din           : return address to push
//   full, empty   : occupancy flags
//   top           : most recently pushed entry (valid when !empty)
// A push on a full stack or a pop on an empty stack leaves the stack unchanged.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra bit so that DEPTH entries is distinguishable from zero entries.
  logic [AW:0]  ptr_q;

  assign full  = (ptr_q == (AW+1)'(DEPTH));
  assign empty = (ptr_q == '0);
  // ptr_q points at the next free slot; at full the low bits wrap to 0, so
  // subtracting one still lands on the last written slot.
  assign top   = mem_q[ptr_q[AW-1:0] - AW'(1)];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/controle_desvio_seq.sv
// controle_desvio_seq: registered branch/jump resolution unit with its own PC.
// Decodes the control opcode, evaluates zero/negativo, updates the PC and opens
// a FLUSH_CYCLES-long flush window after every taken transfer. jal/jmpr use an
// optional return-address stack.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   enable, stall      : unit enable / downstream stall (both hold the PC)
//   inst_valid         : opcode, offset, target_in, zero, negativo valid
//   opcode             : 6-bit control opcode
//   offset             : signed relative branch offset
//   target_in          : absolute target for jmp/jal/jmpr
//   zero, negativo     : ALU flags
//   pc                 : current program counter
//   taken, jump        : 1-cycle pulses after a taken / absolute transfer
//   flush, busy        : high while the flush window is open
//   ras_overflow/underflow : sticky RAS error flags
module controle_desvio_seq
  import ctrl_pkg::*;
#(
  parameter int          ADDR_W       = 9,
  parameter int unsigned RESET_PC     = 0,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          USE_RAS      = 1,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     inst_valid,
  input  logic [5:0]               opcode,
  input  logic signed [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0]        target_in,
  input  logic                     zero,
  input  logic                     negativo,
  input  logic                     stall,
  output logic [ADDR_W-1:0]        pc,
  output logic                     taken,
  output logic                     jump,
  output logic                     flush,
  output logic                     busy,
  output logic                     ras_overflow,
  output logic                     ras_underflow
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic                taken_q, taken_d, jump_q, jump_d;
  logic                ovf_q, unf_q, ovf_set, unf_set;
  logic                accept, push, pop;
  logic                ras_full, ras_empty;
  logic [ADDR_W-1:0]   ras_top;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .full  (ras_full),
    .empty (ras_empty),
    .top   (ras_top)
  );

  assign accept = (state_q == RUN) && enable && inst_valid && !stall;
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    jump_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (accept) begin
      pc_d = pc_inc;
      case (opcode)
        OP_JMP: begin
          taken_d = 1'b1;
          jump_d  = 1'b1;
          pc_d    = target_in;
        end
        OP_JAL: begin
          taken_d = 1'b1;
          jump_d  = 1'b1;
          pc_d    = target_in;
          if (USE_RAS != 0) begin
            // A full stack drops the return address but the call still happens.
            if (ras_full) ovf_set = 1'b1;
            else          push    = 1'b1;
          end
        end
        OP_JMPR: begin
          taken_d = 1'b1;
          jump_d  = 1'b1;
          pc_d    = target_in;
          if (USE_RAS != 0) begin
            // Empty stack falls back to the supplied absolute target.
            if (ras_empty) begin
              unf_set = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = ras_top;
            end
          end
        end
        OP_BEQ, OP_BEQI, OP_BLT, OP_BGRT, OP_BLTI, OP_BGRTI: begin
          if (zero) begin
            taken_d = 1'b1;
            pc_d    = pc_q + offset;
          end
        end
        OP_BNEQ, OP_BNEQI: begin
          if (!zero) begin
            taken_d = 1'b1;
            pc_d    = pc_q + offset;
          end
        end
        OP_BLZ: begin
          if (negativo) begin
            taken_d = 1'b1;
            pc_d    = pc_q + offset;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= ADDR_W'(RESET_PC);
      taken_q <= 1'b0;
      jump_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      jump_q  <= jump_d;
      ovf_q   <= ovf_q | ovf_set;
      unf_q   <= unf_q | unf_set;
      case (state_q)
        RUN: begin
          if (taken_d) begin
            state_q <= FLUSH;
            cnt_q   <= CNT_INIT;
          end
        end
        FLUSH: begin
          // Counts down unconditionally; stall/enable do not stretch the window.
          if (cnt_q == 4'd0) state_q <= RUN;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc            = pc_q;
  assign taken         = taken_q;
  assign jump          = jump_q;
  assign flush         = (state_q == FLUSH);
  assign busy          = (state_q != RUN);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
